statevector_gate_engine: RTL
============================

Name: statevector_gate_engine

Overview:
- Bus master for the dual-port statevector BRAM; applies one 2x2 complex single-qubit gate to every amplitude pair of the statevector, in place.
- Reads the pair (i0, i1) through port A and port B simultaneously, computes the new amplitudes, and writes both back through port A.
- Sits between the gate-sequencer/control registers and statevector_memory.
- Amplitudes are signed fixed point Q1.30 in AMPLITUDE_WIDTH bits (1.0 = 0x40000000).

Parameters:
- NUM_QUBITS, 3, number of qubits; NUM_STATES = 2**NUM_QUBITS.
- AMPLITUDE_WIDTH, 32, width of each re/im component (signed).
- FRAC_BITS, 30, fractional bits of amplitudes and coefficients.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- target_qubit  in  $clog2(NUM_QUBITS)+1  qubit index t
- u00_re, u00_im, u01_re, u01_im, u10_re, u10_im, u11_re, u11_im  in  AMPLITUDE_WIDTH each  gate coefficients, signed Q1.30
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = target_qubit out of range
- mem_porta_en, mem_porta_we  out  1 each  port A enable / write enable
- mem_porta_addr, mem_portb_addr  out  $clog2(NUM_STATES) each  addresses
- mem_porta_din_re, mem_porta_din_im  out  AMPLITUDE_WIDTH each  write data
- mem_porta_dout_re, mem_porta_dout_im, mem_portb_dout_re, mem_portb_dout_im  in  AMPLITUDE_WIDTH each  read data; 1-cycle synchronous read latency
- mem_portb_en  out  1  port B enable

Behaviour:
- Reset and IDLE values: all outputs 0. Reset mid-operation aborts immediately: IDLE, enables low, no done pulse. Memory is left partially updated.
- Start acceptance:
  - start in IDLE latches target_qubit and all 8 coefficients; later input changes are ignored until the next start.
  - start while busy is ignored.
- Range check: if target_qubit >= NUM_QUBITS, the next cycle pulses done=1 and err=1, and no memory enable is asserted.
- Pair index k counts 0..NUM_STATES/2-1.
  - i0 = k with a 0 bit inserted at position t.
  - i1 = i0 | (1<<t).
- FSM, per pair:
  - READ: porta_en=1, we=0, addr=i0; portb_en=1, addr=i1.
  - CAPTURE: register a0 = port A dout and a1 = port B dout; enables low.
  - COMPUTE: compute and register b0 = u00*a0 + u01*a1 and b1 = u10*a0 + u11*a1.
  - WRITE0: porta_en=1, we=1, addr=i0, din=b0.
  - WRITE1: porta_en=1, we=1, addr=i1, din=b1. If k is the last pair, go to DONE; else k+1 and go to READ.
  - DONE: done=1, err=0, busy=0 in this cycle; then IDLE.
- Timing: 5 cycles per pair. With start at cycle 0 in IDLE, the first READ is cycle 1 and done is at cycle 5*NUM_STATES/2 + 1.
- Complex multiply-accumulate:
  - re = sum(ur*ar - ui*ai); im = sum(ur*ai + ui*ar).
  - Full 2*AMPLITUDE_WIDTH products, accumulated with 2 guard bits.
  - Round to nearest: add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
  - Saturate to signed AMPLITUDE_WIDTH range (0x7FFFFFFF / 0x80000000).
- Port B is never written. Port A and port B are never both asserted outside READ.
- t = NUM_QUBITS-1 pairs addresses with stride NUM_STATES/2. t = 0 pairs adjacent addresses. No address wraps.

Test Plan:
- X gate: memory |000> (addr0 re=0x40000000, rest 0); u01=u10=0x40000000, t=0 -> after done, addr1 re=0x40000000, all others 0, err=0.
- Hadamard: memory |000>; u00=u01=u10=0x2D413CCD, u11=0xD2BEC333, t=2 -> addr0 and addr4 re=0x2D413CCD, im=0, all others 0.
- Identity, with timing:
  - Memory addr n holds re=n*100, im=n*200; u00=u11=0x40000000, t=1.
  - Memory must be unchanged, done at exactly cycle 21 after start, busy high cycles 1-20.
  - Address order must be (0,2),(1,3),(4,6),(5,7).
- Saturation: addr0=addr1=re 0x40000000; u00=u01=0x40000000, t=0 -> addr0 re=0x7FFFFFFF. Phase gate u11 im=0x40000000 on a1=1.0 -> addr1 im=0x40000000, re=0.
- Invalid target: t=3 -> done=1 and err=1 in cycle 1, no mem enables ever asserted.
- Abort and ignored start:
  - rst asserted during the second pair -> all outputs 0 the next cycle, no done.
  - A later start runs a full sweep normally.
  - start pulsed while busy -> no restart, a single done.

Source files
------------

// File: rtl/statevector_gate_engine.sv
// statevector_gate_engine
// Applies one 2x2 complex single-qubit gate to every amplitude pair of the
// statevector held in a dual-port BRAM, in place. For each pair (i0, i1) the
// engine reads both amplitudes at once (port A and port B). It then computes
// the new values and writes them back through port A. Each pair takes five
// cycles: READ, CAPTURE, COMPUTE, WRITE0, WRITE1.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 single-cycle request, sampled only while idle
//   target_qubit          qubit index t; t >= NUM_QUBITS ends with err
//   u00..u11 re/im        gate coefficients, signed Q1.FRAC_BITS
//   busy, done, err       status; done is a one-cycle pulse, err valid with done
//   mem_porta_*           port A: enable, write enable, address, write data
//   mem_portb_*           port B: enable, address (read only)
//   mem_port*_dout_*      read data, one-cycle synchronous latency
module statevector_gate_engine #(
  parameter int NUM_QUBITS      = 3,
  parameter int AMPLITUDE_WIDTH = 32,
  parameter int FRAC_BITS       = 30
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [$clog2(NUM_QUBITS):0]            target_qubit,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u00_re,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u00_im,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u01_re,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u01_im,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u10_re,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u10_im,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u11_re,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      u11_im,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic                                   mem_porta_en,
  output logic                                   mem_porta_we,
  output logic [$clog2(2**NUM_QUBITS)-1:0]       mem_porta_addr,
  output logic [$clog2(2**NUM_QUBITS)-1:0]       mem_portb_addr,
  output logic signed [AMPLITUDE_WIDTH-1:0]      mem_porta_din_re,
  output logic signed [AMPLITUDE_WIDTH-1:0]      mem_porta_din_im,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      mem_porta_dout_re,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      mem_porta_dout_im,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      mem_portb_dout_re,
  input  logic signed [AMPLITUDE_WIDTH-1:0]      mem_portb_dout_im,
  output logic                                   mem_portb_en
);

  localparam int NUM_STATES = 2**NUM_QUBITS;
  localparam int ADDR_W     = $clog2(NUM_STATES);
  localparam int T_W        = $clog2(NUM_QUBITS) + 1;
  localparam int W          = AMPLITUDE_WIDTH;
  // Full product width plus two guard bits for the four-term sum.
  localparam int ACC_W      = 2*W + 2;

  localparam logic [ADDR_W-1:0]       LAST_PAIR = ADDR_W'(NUM_STATES/2 - 1);
  localparam logic [T_W-1:0]          T_LIMIT   = T_W'(NUM_QUBITS);
  localparam logic signed [ACC_W-1:0] RND_HALF  = ACC_W'(1) << (FRAC_BITS-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = (ACC_W'(1) << (W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMPUTE = 3'd3,
    S_WRITE0  = 3'd4,
    S_WRITE1  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                 state_r;
  logic [T_W-1:0]         t_r;
  logic [ADDR_W-1:0]      k_r;
  // Coefficient index: 0 = u00, 1 = u01, 2 = u10, 3 = u11.
  logic signed [W-1:0]    cre_r [4];
  logic signed [W-1:0]    cim_r [4];
  logic signed [W-1:0]    a0_re_r, a0_im_r, a1_re_r, a1_im_r;
  logic signed [W-1:0]    b1_re_r, b1_im_r;
  logic signed [W-1:0]    b0_re_s, b0_im_s, b1_re_s, b1_im_s;
  logic                   busy_r, done_r, err_r;
  logic                   pa_en_r, pa_we_r, pb_en_r;
  logic [ADDR_W-1:0]      pa_addr_r, pb_addr_r;
  logic signed [W-1:0]    pa_din_re_r, pa_din_im_r;

  // Pair index k with a zero bit inserted at position t.
  function automatic logic [ADDR_W-1:0] pair_i0(input logic [ADDR_W-1:0] k,
                                                input logic [T_W-1:0]    t);
    logic [ADDR_W-1:0] low_mask;
    low_mask = (ADDR_W'(1) << t) - ADDR_W'(1);
    return ((k & ~low_mask) << 1) | (k & low_mask);
  endfunction

  function automatic logic [ADDR_W-1:0] pair_i1(input logic [ADDR_W-1:0] k,
                                                input logic [T_W-1:0]    t);
    return pair_i0(k, t) | (ADDR_W'(1) << t);
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_mul(input logic signed [W-1:0] x,
                                                       input logic signed [W-1:0] y);
    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] ye;
    xe = {{(ACC_W-W){x[W-1]}}, x};
    ye = {{(ACC_W-W){y[W-1]}}, y};
    return xe * ye;
  endfunction

  // Round to nearest (add half LSB, arithmetic shift), then saturate.
  function automatic logic signed [W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] q;
    q = (acc + RND_HALF) >>> FRAC_BITS;
    if (q > SAT_MAX) begin
      return SAT_MAX[W-1:0];
    end else if (q < SAT_MIN) begin
      return SAT_MIN[W-1:0];
    end else begin
      return q[W-1:0];
    end
  endfunction

  // New pair amplitudes from the captured pair and the latched gate.
  always_comb begin
    b0_re_s = round_sat(sext_mul(cre_r[0], a0_re_r) - sext_mul(cim_r[0], a0_im_r)
                      + sext_mul(cre_r[1], a1_re_r) - sext_mul(cim_r[1], a1_im_r));
    b0_im_s = round_sat(sext_mul(cre_r[0], a0_im_r) + sext_mul(cim_r[0], a0_re_r)
                      + sext_mul(cre_r[1], a1_im_r) + sext_mul(cim_r[1], a1_re_r));
    b1_re_s = round_sat(sext_mul(cre_r[2], a0_re_r) - sext_mul(cim_r[2], a0_im_r)
                      + sext_mul(cre_r[3], a1_re_r) - sext_mul(cim_r[3], a1_im_r));
    b1_im_s = round_sat(sext_mul(cre_r[2], a0_im_r) + sext_mul(cim_r[2], a0_re_r)
                      + sext_mul(cre_r[3], a1_im_r) + sext_mul(cim_r[3], a1_re_r));
  end

  // Sweep FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      t_r         <= '0;
      k_r         <= '0;
      for (int i = 0; i < 4; i++) begin
        cre_r[i] <= '0;
        cim_r[i] <= '0;
      end
      a0_re_r     <= '0;
      a0_im_r     <= '0;
      a1_re_r     <= '0;
      a1_im_r     <= '0;
      b1_re_r     <= '0;
      b1_im_r     <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      pa_en_r     <= 1'b0;
      pa_we_r     <= 1'b0;
      pb_en_r     <= 1'b0;
      pa_addr_r   <= '0;
      pb_addr_r   <= '0;
      pa_din_re_r <= '0;
      pa_din_im_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          if (start) begin
            t_r      <= target_qubit;
            k_r      <= '0;
            cre_r[0] <= u00_re;
            cim_r[0] <= u00_im;
            cre_r[1] <= u01_re;
            cim_r[1] <= u01_im;
            cre_r[2] <= u10_re;
            cim_r[2] <= u10_im;
            cre_r[3] <= u11_re;
            cim_r[3] <= u11_im;
            if (target_qubit >= T_LIMIT) begin
              // Out-of-range target: report immediately, never touch memory.
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else begin
              state_r   <= S_READ;
              busy_r    <= 1'b1;
              pa_en_r   <= 1'b1;
              pb_en_r   <= 1'b1;
              pa_addr_r <= pair_i0({ADDR_W{1'b0}}, target_qubit);
              pb_addr_r <= pair_i1({ADDR_W{1'b0}}, target_qubit);
            end
          end
        end
        S_READ: begin
          state_r   <= S_CAPTURE;
          pa_en_r   <= 1'b0;
          pb_en_r   <= 1'b0;
          pa_addr_r <= '0;
          pb_addr_r <= '0;
        end
        S_CAPTURE: begin
          state_r <= S_COMPUTE;
          a0_re_r <= mem_porta_dout_re;
          a0_im_r <= mem_porta_dout_im;
          a1_re_r <= mem_portb_dout_re;
          a1_im_r <= mem_portb_dout_im;
        end
        S_COMPUTE: begin
          // b0 goes straight into the write-data register; b1 waits a cycle.
          state_r     <= S_WRITE0;
          b1_re_r     <= b1_re_s;
          b1_im_r     <= b1_im_s;
          pa_en_r     <= 1'b1;
          pa_we_r     <= 1'b1;
          pa_addr_r   <= pair_i0(k_r, t_r);
          pa_din_re_r <= b0_re_s;
          pa_din_im_r <= b0_im_s;
        end
        S_WRITE0: begin
          state_r     <= S_WRITE1;
          pa_addr_r   <= pair_i1(k_r, t_r);
          pa_din_re_r <= b1_re_r;
          pa_din_im_r <= b1_im_r;
        end
        S_WRITE1: begin
          pa_we_r     <= 1'b0;
          pa_din_re_r <= '0;
          pa_din_im_r <= '0;
          if (k_r == LAST_PAIR) begin
            state_r   <= S_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            pa_en_r   <= 1'b0;
            pa_addr_r <= '0;
          end else begin
            state_r   <= S_READ;
            k_r       <= k_r + ADDR_W'(1);
            pa_en_r   <= 1'b1;
            pb_en_r   <= 1'b1;
            pa_addr_r <= pair_i0(k_r + ADDR_W'(1), t_r);
            pb_addr_r <= pair_i1(k_r + ADDR_W'(1), t_r);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          pa_en_r <= 1'b0;
          pa_we_r <= 1'b0;
          pb_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign err              = err_r;
  assign mem_porta_en     = pa_en_r;
  assign mem_porta_we     = pa_we_r;
  assign mem_porta_addr   = pa_addr_r;
  assign mem_portb_addr   = pb_addr_r;
  assign mem_porta_din_re = pa_din_re_r;
  assign mem_porta_din_im = pa_din_im_r;
  assign mem_portb_en     = pb_en_r;

endmodule
